// File: rtl/idma_inst64_decode.sv
// inst64 DMA frontend decode/issue: stages copy configuration, launches backend requests, answers status queries.
// Optional define IDMA_INST64_DECODE_USER_EN adds the DMUSER register feeding be_req_user_o.
module idma_inst64_decode #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned TfIdWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 acc_req_valid_i,
    output logic                 acc_req_ready_o,
    input  logic [31:0]          acc_req_op_i,
    input  logic [63:0]          acc_req_arga_i,
    input  logic [63:0]          acc_req_argb_i,
    input  logic [IdWidth-1:0]   acc_req_id_i,
    output logic                 acc_rsp_valid_o,
    input  logic                 acc_rsp_ready_i,
    output logic [63:0]          acc_rsp_data_o,
    output logic [IdWidth-1:0]   acc_rsp_id_o,
    output logic                 be_req_valid_o,
    input  logic                 be_req_ready_i,
    output logic [AddrWidth-1:0] be_req_src_o,
    output logic [AddrWidth-1:0] be_req_dst_o,
    output logic [AddrWidth-1:0] be_req_len_o,
    output logic [AddrWidth-1:0] be_req_src_stride_o,
    output logic [AddrWidth-1:0] be_req_dst_stride_o,
    output logic [AddrWidth-1:0] be_req_reps_o,
    output logic                 be_req_decouple_o,
    output logic                 be_req_2d_o,
    output logic [63:0]          be_req_user_o,
    input  logic                 be_done_i
);

    // OP-CUSTOM1 (0x2b) encodings; config ops also require rd == 0.
    localparam logic [31:0] MaskRd   = 32'hfe00_707f;
    localparam logic [31:0] MaskCfg  = 32'hfe00_7fff;
    localparam logic [31:0] MaskRep  = 32'hfff0_7fff;
    localparam logic [31:0] MatchSrc   = 32'h0000_002b;
    localparam logic [31:0] MatchDst   = 32'h0200_002b;
    localparam logic [31:0] MatchCpyi  = 32'h0400_002b;
    localparam logic [31:0] MatchCpy   = 32'h0600_002b;
    localparam logic [31:0] MatchStati = 32'h0800_002b;
    localparam logic [31:0] MatchStat  = 32'h0a00_002b;
    localparam logic [31:0] MatchStr   = 32'h0c00_002b;
    localparam logic [31:0] MatchRep   = 32'h0e00_002b;

    typedef enum logic [1:0] {Idle, Launch, Resp} state_e;
    state_e state_q, state_d;

    logic is_src, is_dst, is_str, is_rep, is_cpy, is_cpyi, is_stat, is_stati;
    logic is_copy, is_status;
    logic req_hs, be_hs;
    logic [1:0]  copy_cfg, status_sel;
    logic [63:0] status_val;

    logic [AddrWidth-1:0] src_q, dst_q, sstr_q, dstr_q, reps_q;
    logic [AddrWidth-1:0] be_src_q, be_dst_q, be_len_q, be_sstr_q, be_dstr_q, be_reps_q;
    logic                 be_decouple_q, be_2d_q;
    logic [63:0]          rsp_data_q;
    logic [IdWidth-1:0]   rsp_id_q;
    logic [TfIdWidth-1:0] next_id, completed_id;

    assign is_src   = (acc_req_op_i & MaskCfg) == MatchSrc;
    assign is_dst   = (acc_req_op_i & MaskCfg) == MatchDst;
    assign is_str   = (acc_req_op_i & MaskCfg) == MatchStr;
    assign is_rep   = (acc_req_op_i & MaskRep) == MatchRep;
    assign is_cpyi  = (acc_req_op_i & MaskRd)  == MatchCpyi;
    assign is_cpy   = (acc_req_op_i & MaskRd)  == MatchCpy;
    assign is_stati = (acc_req_op_i & MaskRd)  == MatchStati;
    assign is_stat  = (acc_req_op_i & MaskRd)  == MatchStat;
    assign is_copy   = is_cpy | is_cpyi;
    assign is_status = is_stat | is_stati;

    assign copy_cfg   = is_cpy  ? acc_req_argb_i[1:0] : acc_req_op_i[21:20];
    assign status_sel = is_stat ? acc_req_argb_i[1:0] : acc_req_op_i[21:20];

    assign req_hs = acc_req_valid_i & acc_req_ready_o;
    assign be_hs  = be_req_valid_o & be_req_ready_i;

    logic unused_arg_hi;
    assign unused_arg_hi = ^{acc_req_arga_i[63:AddrWidth], acc_req_argb_i[63:AddrWidth]};

    always_comb begin
        status_val = '0;
        unique case (status_sel)
            2'd0: status_val = 64'(completed_id);
            2'd1: status_val = 64'(next_id);
            2'd2: status_val = {63'd0, (completed_id != next_id) | be_req_valid_o};
            default: status_val = {63'd0, be_req_valid_o};
        endcase
    end

    always_comb begin
        state_d         = state_q;
        acc_req_ready_o = 1'b0;
        be_req_valid_o  = 1'b0;
        acc_rsp_valid_o = 1'b0;
        unique case (state_q)
            Idle: begin
                acc_req_ready_o = 1'b1;
                if (acc_req_valid_i) begin
                    if (is_copy)        state_d = Launch;
                    else if (is_status) state_d = Resp;
                end
            end
            Launch: begin
                be_req_valid_o = 1'b1;
                if (be_req_ready_i) state_d = Resp;
            end
            Resp: begin
                acc_rsp_valid_o = 1'b1;
                if (acc_rsp_ready_i) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q         <= '0;
            dst_q         <= '0;
            sstr_q        <= '0;
            dstr_q        <= '0;
            reps_q        <= '0;
            be_src_q      <= '0;
            be_dst_q      <= '0;
            be_len_q      <= '0;
            be_sstr_q     <= '0;
            be_dstr_q     <= '0;
            be_reps_q     <= '0;
            be_decouple_q <= 1'b0;
            be_2d_q       <= 1'b0;
            rsp_data_q    <= '0;
            rsp_id_q      <= '0;
        end else begin
            if (req_hs) begin
                if (is_src) src_q <= AddrWidth'({acc_req_argb_i[31:0], acc_req_arga_i[31:0]});
                if (is_dst) dst_q <= AddrWidth'({acc_req_argb_i[31:0], acc_req_arga_i[31:0]});
                if (is_str) begin
                    sstr_q <= AddrWidth'(acc_req_arga_i);
                    dstr_q <= AddrWidth'(acc_req_argb_i);
                end
                if (is_rep) reps_q <= AddrWidth'(acc_req_arga_i);
                // Without 2D the backend expects a single repetition and zero strides.
                if (is_copy) begin
                    be_src_q      <= src_q;
                    be_dst_q      <= dst_q;
                    be_len_q      <= AddrWidth'(acc_req_arga_i);
                    be_sstr_q     <= copy_cfg[1] ? sstr_q : '0;
                    be_dstr_q     <= copy_cfg[1] ? dstr_q : '0;
                    be_reps_q     <= copy_cfg[1] ? reps_q : AddrWidth'(1);
                    be_decouple_q <= copy_cfg[0];
                    be_2d_q       <= copy_cfg[1];
                    rsp_id_q      <= acc_req_id_i;
                end
                if (is_status) begin
                    rsp_data_q <= status_val;
                    rsp_id_q   <= acc_req_id_i;
                end
            end
            if (be_hs) rsp_data_q <= 64'(next_id);
        end
    end

    // A done with nothing outstanding is spurious and must not overtake next_id.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_id      <= '0;
            completed_id <= '0;
        end else begin
            if (be_hs) next_id <= next_id + TfIdWidth'(1);
            if (be_done_i && (completed_id != next_id)) completed_id <= completed_id + TfIdWidth'(1);
        end
    end

`ifdef IDMA_INST64_DECODE_USER_EN
    localparam logic [31:0] MatchUser = 32'h1000_002b;
    logic        is_user;
    logic [63:0] user_q, be_user_q;
    assign is_user = (acc_req_op_i & MaskCfg) == MatchUser;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            user_q    <= '0;
            be_user_q <= '0;
        end else if (req_hs) begin
            if (is_user) user_q <= {acc_req_argb_i[31:0], acc_req_arga_i[31:0]};
            if (is_copy) be_user_q <= user_q;
        end
    end
    assign be_req_user_o = be_user_q;
`else
    assign be_req_user_o = '0;
`endif

    assign acc_rsp_data_o      = rsp_data_q;
    assign acc_rsp_id_o        = rsp_id_q;
    assign be_req_src_o        = be_src_q;
    assign be_req_dst_o        = be_dst_q;
    assign be_req_len_o        = be_len_q;
    assign be_req_src_stride_o = be_sstr_q;
    assign be_req_dst_stride_o = be_dstr_q;
    assign be_req_reps_o       = be_reps_q;
    assign be_req_decouple_o   = be_decouple_q;
    assign be_req_2d_o         = be_2d_q;

endmodule

// File: tb/tb_idma_inst64_decode.sv
// Bench for idma_inst64_decode: vector table plus hand sequences for stalls, counters, wrap and reset.
// A second instance with a 4-bit transfer counter exercises modulo wrap.
`timescale 1ns/1ps
module tb_idma_inst64_decode;
    localparam int AW = 48;
    localparam int DW = 6 * AW + 2 + 64;
    localparam int RW = 5 + 64;
    localparam int NV = 10;
`ifdef IDMA_INST64_DECODE_USER_EN
    localparam logic [63:0] USER_EXP = 64'h0000_00CD_0000_00AB;
`else
    localparam logic [63:0] USER_EXP = 64'h0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          acc_req_valid_i, acc_req_ready_o;
    logic [31:0]   acc_req_op_i;
    logic [63:0]   acc_req_arga_i, acc_req_argb_i;
    logic [4:0]    acc_req_id_i;
    logic          acc_rsp_valid_o, acc_rsp_ready_i;
    logic [63:0]   acc_rsp_data_o;
    logic [4:0]    acc_rsp_id_o;
    logic          be_req_valid_o, be_req_ready_i;
    logic [AW-1:0] be_req_src_o, be_req_dst_o, be_req_len_o;
    logic [AW-1:0] be_req_src_stride_o, be_req_dst_stride_o, be_req_reps_o;
    logic          be_req_decouple_o, be_req_2d_o;
    logic [63:0]   be_req_user_o;
    logic          be_done_i;

    logic          w_unused_req_ready, w_rsp_valid, w_unused_be_valid;
    logic [63:0]   w_rsp_data, w_unused_user;
    logic [4:0]    w_rsp_id;
    logic [AW-1:0] w_unused_src, w_unused_dst, w_unused_len, w_unused_ss, w_unused_ds, w_unused_reps;
    logic          w_unused_dec, w_unused_2d;

    idma_inst64_decode dut (
        .clk_i(clk), .rst_i(rst),
        .acc_req_valid_i(acc_req_valid_i), .acc_req_ready_o(acc_req_ready_o),
        .acc_req_op_i(acc_req_op_i), .acc_req_arga_i(acc_req_arga_i),
        .acc_req_argb_i(acc_req_argb_i), .acc_req_id_i(acc_req_id_i),
        .acc_rsp_valid_o(acc_rsp_valid_o), .acc_rsp_ready_i(acc_rsp_ready_i),
        .acc_rsp_data_o(acc_rsp_data_o), .acc_rsp_id_o(acc_rsp_id_o),
        .be_req_valid_o(be_req_valid_o), .be_req_ready_i(be_req_ready_i),
        .be_req_src_o(be_req_src_o), .be_req_dst_o(be_req_dst_o), .be_req_len_o(be_req_len_o),
        .be_req_src_stride_o(be_req_src_stride_o), .be_req_dst_stride_o(be_req_dst_stride_o),
        .be_req_reps_o(be_req_reps_o), .be_req_decouple_o(be_req_decouple_o),
        .be_req_2d_o(be_req_2d_o), .be_req_user_o(be_req_user_o), .be_done_i(be_done_i)
    );

    idma_inst64_decode #(.TfIdWidth(4)) dut_w (
        .clk_i(clk), .rst_i(rst),
        .acc_req_valid_i(acc_req_valid_i), .acc_req_ready_o(w_unused_req_ready),
        .acc_req_op_i(acc_req_op_i), .acc_req_arga_i(acc_req_arga_i),
        .acc_req_argb_i(acc_req_argb_i), .acc_req_id_i(acc_req_id_i),
        .acc_rsp_valid_o(w_rsp_valid), .acc_rsp_ready_i(acc_rsp_ready_i),
        .acc_rsp_data_o(w_rsp_data), .acc_rsp_id_o(w_rsp_id),
        .be_req_valid_o(w_unused_be_valid), .be_req_ready_i(be_req_ready_i),
        .be_req_src_o(w_unused_src), .be_req_dst_o(w_unused_dst), .be_req_len_o(w_unused_len),
        .be_req_src_stride_o(w_unused_ss), .be_req_dst_stride_o(w_unused_ds),
        .be_req_reps_o(w_unused_reps), .be_req_decouple_o(w_unused_dec),
        .be_req_2d_o(w_unused_2d), .be_req_user_o(w_unused_user), .be_done_i(be_done_i)
    );

    logic [DW-1:0] act_desc;
    assign act_desc = {be_req_src_o, be_req_dst_o, be_req_len_o, be_req_src_stride_o,
                       be_req_dst_stride_o, be_req_reps_o, be_req_decouple_o, be_req_2d_o, be_req_user_o};

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] be_q[$];
    logic [RW-1:0] rsp_q[$];
    logic [RW-1:0] w_q[$];
    bit w_chk = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_desc(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got id/data %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected or not seen in time", name);
    endtask

    function automatic logic [DW-1:0] desc(input logic [AW-1:0] s, d, l, ss, ds, r,
                                           input logic dec, d2, input logic [63:0] u);
        return {s, d, l, ss, ds, r, dec, d2, u};
    endfunction

    // Scoreboard: handshakes seen just before the next rising edge are compared against the queues.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (be_req_valid_o && be_req_ready_i) begin
                if (be_q.size() == 0) flag("be_unexpected");
                else check_desc("be_desc", act_desc, be_q.pop_front());
            end
            if (acc_rsp_valid_o && acc_rsp_ready_i) begin
                if (rsp_q.size() == 0) flag("rsp_unexpected");
                else check_rsp("rsp", {acc_rsp_id_o, acc_rsp_data_o}, rsp_q.pop_front());
            end
            if (w_chk && w_rsp_valid && acc_rsp_ready_i) begin
                if (w_q.size() == 0) flag("wrap_rsp_unexpected");
                else check_rsp("wrap_rsp", {w_rsp_id, w_rsp_data}, w_q.pop_front());
            end
        end
    end

    task automatic offload(input logic [31:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] id);
        int n = 0;
        @(negedge clk);
        acc_req_op_i    = op;
        acc_req_arga_i  = a;
        acc_req_argb_i  = b;
        acc_req_id_i    = id;
        acc_req_valid_i = 1'b1;
        while (!acc_req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!acc_req_ready_o) begin
            flag("offload_timeout");
            acc_req_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1 acc_req_valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(acc_req_ready_o && !acc_rsp_valid_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) flag("idle_timeout");
    endtask

    task automatic done_pulse();
        @(negedge clk);
        be_done_i = 1'b1;
        @(negedge clk);
        be_done_i = 1'b0;
    endtask

    typedef struct {
        logic [31:0]   op;
        logic [63:0]   a;
        logic [63:0]   b;
        logic [4:0]    id;
        bit            has_be;
        logic [DW-1:0] be;
        bit            has_rsp;
        logic [63:0]   rsp;
    } vec_t;
    vec_t vecs[NV];

    initial begin
        vecs[0] = '{32'h0000002b, 64'h1000, 64'h0, 5'd0, 1'b0, '0, 1'b0, 64'h0};
        vecs[1] = '{32'h0200002b, 64'h2000, 64'h0, 5'd0, 1'b0, '0, 1'b0, 64'h0};
        vecs[2] = '{32'h040000ab, 64'h40, 64'h0, 5'd3, 1'b1,
                    desc(48'h1000, 48'h2000, 48'h40, 48'h0, 48'h0, 48'h1, 1'b0, 1'b0, 64'h0), 1'b1, 64'h0};
        vecs[3] = '{32'h081000ab, 64'h0, 64'h0, 5'd4, 1'b0, '0, 1'b1, 64'h1};
        vecs[4] = '{32'h0000002b, 64'hFFFF_FFFF_8765_4321, 64'hAAAA_BBBB_0000_1234, 5'd0, 1'b0, '0, 1'b0, 64'h0};
        vecs[5] = '{32'h041000ab, 64'hFFFF_0000_0000_0080, 64'h0, 5'd5, 1'b1,
                    desc(48'h1234_8765_4321, 48'h2000, 48'h80, 48'h0, 48'h0, 48'h1, 1'b1, 1'b0, 64'h0), 1'b1, 64'h1};
        vecs[6] = '{32'h00000033, 64'h5, 64'h6, 5'd1, 1'b0, '0, 1'b0, 64'h0};
        vecs[7] = '{32'h0a0000ab, 64'h0, 64'h5, 5'd6, 1'b0, '0, 1'b1, 64'h2};
        vecs[8] = '{32'h0a0000ab, 64'h0, 64'h4, 5'd7, 1'b0, '0, 1'b1, 64'h0};
        vecs[9] = '{32'h0e00002b, 64'h7, 64'h0, 5'd0, 1'b0, '0, 1'b0, 64'h0};

        rst = 1'b1;
        acc_req_valid_i = 1'b0;
        acc_req_op_i = '0;
        acc_req_arga_i = '0;
        acc_req_argb_i = '0;
        acc_req_id_i = '0;
        acc_rsp_ready_i = 1'b1;
        be_req_ready_i = 1'b1;
        be_done_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check1("reset_req_ready", acc_req_ready_o, 1'b1);
        check1("reset_be_valid", be_req_valid_o, 1'b0);
        check1("reset_rsp_valid", acc_rsp_valid_o, 1'b0);
        check64("reset_rsp_data", acc_rsp_data_o, 64'h0);
        check64("reset_rsp_id", {59'd0, acc_rsp_id_o}, 64'h0);
        check_desc("reset_desc", act_desc, '0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].has_be) be_q.push_back(vecs[i].be);
            if (vecs[i].has_rsp) rsp_q.push_back({vecs[i].id, vecs[i].rsp});
            offload(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].id);
        end
        wait_idle();

        // 2D copy with the backend stalled for five cycles.
        offload(32'h0c00002b, 64'h100, 64'h200, 5'd0);
        offload(32'h0e00002b, 64'h4, 64'h0, 5'd0);
        be_req_ready_i = 1'b0;
        be_q.push_back(desc(48'h1234_8765_4321, 48'h2000, 48'h10, 48'h100, 48'h200, 48'h4, 1'b0, 1'b1, 64'h0));
        rsp_q.push_back({5'd8, 64'h2});
        offload(32'h060000ab, 64'h10, 64'h2, 5'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("stall_be_valid", be_req_valid_o, 1'b1);
            check1("stall_req_ready", acc_req_ready_o, 1'b0);
            check_desc("stall_desc", act_desc,
                       desc(48'h1234_8765_4321, 48'h2000, 48'h10, 48'h100, 48'h200, 48'h4, 1'b0, 1'b1, 64'h0));
        end
        be_req_ready_i = 1'b1;
        @(negedge clk);
        check1("launch_to_rsp", acc_rsp_valid_o, 1'b1);
        wait_idle();

        // Outstanding transfers and completion tracking.
        rsp_q.push_back({5'd9, 64'h1});
        offload(32'h0a0000ab, 64'h0, 64'h2, 5'd9);
        done_pulse();
        done_pulse();
        rsp_q.push_back({5'd10, 64'h2});
        offload(32'h080000ab, 64'h0, 64'h0, 5'd10);
        done_pulse();
        rsp_q.push_back({5'd10, 64'h0});
        offload(32'h0a0000ab, 64'h0, 64'h2, 5'd10);
        done_pulse();
        rsp_q.push_back({5'd10, 64'h3});
        offload(32'h080000ab, 64'h0, 64'h0, 5'd10);
        rsp_q.push_back({5'd10, 64'h0});
        offload(32'h083000ab, 64'h0, 64'h0, 5'd10);
        wait_idle();

        // Response backpressure.
        acc_rsp_ready_i = 1'b0;
        rsp_q.push_back({5'd11, 64'h3});
        offload(32'h081000ab, 64'h0, 64'h0, 5'd11);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("bp_rsp_valid", acc_rsp_valid_o, 1'b1);
            check1("bp_req_ready", acc_req_ready_o, 1'b0);
            check64("bp_rsp_data", acc_rsp_data_o, 64'h3);
            check64("bp_rsp_id", {59'd0, acc_rsp_id_o}, 64'd11);
        end
        acc_rsp_ready_i = 1'b1;
        wait_idle();

        // User field (an unknown op when the feature is compiled out).
        offload(32'h1000002b, 64'hAB, 64'hCD, 5'd0);
        be_q.push_back(desc(48'h1234_8765_4321, 48'h2000, 48'h8, 48'h0, 48'h0, 48'h1, 1'b0, 1'b0, USER_EXP));
        rsp_q.push_back({5'd13, 64'h3});
        offload(32'h040000ab, 64'h8, 64'h0, 5'd13);
        wait_idle();

        // Reset while a launch is pending.
        be_req_ready_i = 1'b0;
        offload(32'h040000ab, 64'h20, 64'h0, 5'd14);
        @(negedge clk);
        check1("launch_pending", be_req_valid_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check1("rst_be_valid", be_req_valid_o, 1'b0);
        check1("rst_rsp_valid", acc_rsp_valid_o, 1'b0);
        check1("rst_req_ready", acc_req_ready_o, 1'b1);
        rst = 1'b0;
        be_req_ready_i = 1'b1;
        rsp_q.push_back({5'd1, 64'h0});
        offload(32'h081000ab, 64'h0, 64'h0, 5'd1);
        rsp_q.push_back({5'd2, 64'h0});
        offload(32'h080000ab, 64'h0, 64'h0, 5'd2);
        wait_idle();

        // Counter wrap on the 4-bit instance, then launch and done in the same cycle.
        for (int i = 0; i < 15; i++) begin
            be_q.push_back(desc(48'h0, 48'h0, AW'(i), 48'h0, 48'h0, 48'h1, 1'b0, 1'b0, 64'h0));
            rsp_q.push_back({5'd12, 64'(i)});
            offload(32'h040000ab, 64'(i), 64'h0, 5'd12);
        end
        for (int i = 0; i < 15; i++) done_pulse();
        wait_idle();
        w_chk = 1'b1;
        be_q.push_back(desc(48'h0, 48'h0, 48'h33, 48'h0, 48'h0, 48'h1, 1'b0, 1'b0, 64'h0));
        rsp_q.push_back({5'd12, 64'd15});
        w_q.push_back({5'd12, 64'hF});
        offload(32'h040000ab, 64'h33, 64'h0, 5'd12);
        rsp_q.push_back({5'd12, 64'd16});
        w_q.push_back({5'd12, 64'd0});
        offload(32'h081000ab, 64'h0, 64'h0, 5'd12);
        wait_idle();
        be_req_ready_i = 1'b0;
        be_q.push_back(desc(48'h0, 48'h0, 48'h44, 48'h0, 48'h0, 48'h1, 1'b0, 1'b0, 64'h0));
        rsp_q.push_back({5'd12, 64'd16});
        w_q.push_back({5'd12, 64'd0});
        offload(32'h040000ab, 64'h44, 64'h0, 5'd12);
        @(negedge clk);
        be_req_ready_i = 1'b1;
        be_done_i = 1'b1;
        @(negedge clk);
        be_done_i = 1'b0;
        rsp_q.push_back({5'd12, 64'd16});
        w_q.push_back({5'd12, 64'd0});
        offload(32'h080000ab, 64'h0, 64'h0, 5'd12);
        rsp_q.push_back({5'd12, 64'd17});
        w_q.push_back({5'd12, 64'd1});
        offload(32'h081000ab, 64'h0, 64'h0, 5'd12);
        rsp_q.push_back({5'd12, 64'd1});
        w_q.push_back({5'd12, 64'd1});
        offload(32'h0a0000ab, 64'h0, 64'h2, 5'd12);
        wait_idle();
        repeat (2) @(negedge clk);

        check64("be_q_drained", 64'(be_q.size()), 64'h0);
        check64("rsp_q_drained", 64'(rsp_q.size()), 64'h0);
        check64("wrap_q_drained", 64'(w_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/idma_inst64_decode.md
# idma_inst64_decode

Decode and issue stage of the `inst64` DMA frontend. Consumes Snitch accelerator-port offloads carrying the DMA opcodes (DMSRC, DMDST, DMSTR, DMREP, DMUSER, DMCPY/DMCPYI, DMSTAT/DMSTATI), stages transfer configuration in registers and launches one backend request per copy. Returns transfer IDs and status words to the core over the accelerator response channel. Tracks issued and completed transfer counts.

## Interface
- `AddrWidth`, 48: backend address/length/stride width; upper operand bits are dropped.
- `IdWidth`, 5: accelerator request ID (destination register tag) width.
- `TfIdWidth`, 32: transfer counter width; zero-extended to 64 in responses.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `acc_req_valid_i` / `acc_req_ready_o` in/out 1: offload handshake.
- `acc_req_op_i` in 32: instruction word.
- `acc_req_arga_i`, `acc_req_argb_i` in 64: rs1, rs2 values.
- `acc_req_id_i` in IdWidth: response tag.
- `acc_rsp_valid_o` / `acc_rsp_ready_i` out/in 1: response handshake.
- `acc_rsp_data_o` out 64, `acc_rsp_id_o` out IdWidth: write-back value and tag.
- `be_req_valid_o` / `be_req_ready_i` out/in 1: backend handshake.
- `be_req_src_o`, `be_req_dst_o`, `be_req_len_o`, `be_req_src_stride_o`, `be_req_dst_stride_o`, `be_req_reps_o` out AddrWidth: transfer descriptor.
- `be_req_decouple_o`, `be_req_2d_o` out 1: config bits.
- `be_req_user_o` out 64: user field.
- `be_done_i` in 1: one-cycle pulse per completed transfer.

## Operation
- Decode by masked compare against the inst64 encodings; unmatched ops are accepted and dropped with no response.
- Config writes (no response, stay IDLE):
  - DMSRC: src = {argb[31:0], arga[31:0]}.
  - DMDST: dst likewise.
  - DMSTR: src_stride = arga, dst_stride = argb.
  - DMREP: reps = arga.
  - DMUSER: user = {argb[31:0], arga[31:0]}.
- Copy: DMCPY uses len = arga, cfg = argb[1:0]; DMCPYI uses cfg = op[21:20]. cfg[0] is decouple, cfg[1] is 2D.
  - 2D clear: descriptor carries reps = 1 and both strides = 0.
- Status: sel = argb[1:0] for DMSTAT, op[21:20] for DMSTATI.
  - 0: completed_id. 1: next_id.
  - 2: busy = (completed_id != next_id) | be_req_valid_o.
  - 3: be_req_valid_o.
  - Status sel bits above [1:0] are ignored.
- FSM:
  - IDLE: `acc_req_ready_o` = 1.
    - Copy handshake → LAUNCH; latch descriptor and tag.
    - Status handshake → RESP; latch value and tag.
    - Config/unknown op → stay IDLE.
  - LAUNCH: `be_req_valid_o` = 1, descriptor stable. On `be_req_ready_i` → RESP with data = next_id (pre-increment); next_id += 1.
  - RESP: `acc_rsp_valid_o` = 1, data/id stable. On `acc_rsp_ready_i` → IDLE.
  - `acc_req_ready_o` = 0 in LAUNCH and RESP.
- Counters: TfIdWidth bits, modulo wrap. Transfer k is complete when completed_id has advanced past k (modular).
  - `be_done_i` increments completed_id.
  - `be_done_i` is ignored when completed_id == next_id.
  - A launch and a done in the same cycle update both counters independently.

## Timing
- Reset values: state IDLE; all outputs 0 except `acc_req_ready_o` = 1; all config registers 0; next_id = completed_id = 0.
- Config write: registers update on the handshake edge. A copy accepted in the next cycle sees the new values.
- Copy: `be_req_valid_o` asserts the cycle after the acc handshake.
  - `acc_rsp_valid_o` asserts the cycle after the backend handshake.
  - Minimum latency from offload to response is 2 cycles.
- Status: response the cycle after the handshake. The value is sampled at the handshake edge.
- Valids are never withdrawn before their handshake.
- Reset mid-operation: the pending request/response is dropped; valids are low in the cycle after reset is sampled.

## Configuration
- `IDMA_INST64_DECODE_USER_EN` defined: DMUSER is decoded and the user register drives `be_req_user_o`.
- Macro undefined:
  - DMUSER is an unknown op: accepted and dropped.
  - The user register is not implemented.
  - `be_req_user_o` is tied to 0.

## Test plan
- DMSRC(arga=0x1000, argb=0), DMDST(0x2000, 0), DMCPYI(len=0x40, imm=0), tag 3, `be_req_ready_i` held 1 → descriptor src 0x1000, dst 0x2000, len 0x40, reps 1, strides 0; response data 0, id 3; next_id = 1.
- DMSTR(0x100, 0x200), DMREP(4), DMCPY(arga=0x10, argb=2), `be_req_ready_i` stalled 5 cycles → valid and descriptor held stable; 2D = 1, reps 4, strides 0x100/0x200; `acc_req_ready_o` = 0 throughout.
- Three copies, then DMSTAT sel 2 → 1; then two `be_done_i` pulses, DMSTATI sel 0 → 2; third pulse, sel 2 → 0; an extra pulse leaves completed_id at 3.
- Backpressure `acc_rsp_ready_i` = 0 for 4 cycles on a DMSTAT → data/id stable; a following offload is not accepted until the response handshake.
- next_id preset near wrap (issue 2^TfIdWidth−1 launches or force counters) → launch returns 0xFFFFFFFF and next_id becomes 0; launch and done in the same cycle update both counters.
- DMUSER(0xAB, 0xCD) then copy → with macro, user 0x000000CD000000AB; without macro, user 0 and no response to DMUSER. Reset asserted while in LAUNCH → valids low the next cycle, counters 0.
